// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared state type and width helper for the sequential Booth multiplier
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // One guard bit above the operand width lets unsigned operands ride through signed Booth recoding.
    function automatic int calc_w1(input int width);
        return width + 1;
    endfunction

endpackage

// File: rtl/booth_datapath.sv
// rtl/booth_datapath.sv - A/Q/Qprev/M registers with one radix-2 Booth add/sub/shift per step
module booth_datapath #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_load,
    input  logic                 i_clear,
    input  logic                 i_step,
    input  logic                 i_signed_mode,
    input  logic [WIDTH-1:0]     i_multiplicand,
    input  logic [WIDTH-1:0]     i_multiplier,
    output logic [2*WIDTH-1:0]   o_product
);
    import mult_pkg::*;

    localparam int W1 = calc_w1(WIDTH);

    logic [W1-1:0] r_a;
    logic [W1-1:0] r_q;
    logic [W1-1:0] r_m;
    logic          r_qprev;

    logic [W1-1:0] w_m_ext;
    logic [W1-1:0] w_q_ext;
    logic [W1-1:0] w_sum;

    // Operand extension and the Booth add/subtract decision, all modulo 2^W1.
    always_comb begin
        w_m_ext = {i_signed_mode & i_multiplicand[WIDTH-1], i_multiplicand};
        w_q_ext = {i_signed_mode & i_multiplier[WIDTH-1], i_multiplier};
        w_sum   = r_a;
        case ({r_q[0], r_qprev})
            2'b01:   w_sum = r_a + r_m;
            2'b10:   w_sum = r_a - r_m;
            default: w_sum = r_a;
        endcase
    end

    // Register file: clear wins over load, load wins over step; arithmetic shift keeps the sum's MSB.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a     <= '0;
            r_q     <= '0;
            r_m     <= '0;
            r_qprev <= 1'b0;
        end else if (i_clear) begin
            r_a     <= '0;
            r_q     <= '0;
            r_m     <= '0;
            r_qprev <= 1'b0;
        end else if (i_load) begin
            r_a     <= '0;
            r_q     <= w_q_ext;
            r_m     <= w_m_ext;
            r_qprev <= 1'b0;
        end else if (i_step) begin
            r_a     <= {w_sum[W1-1], w_sum[W1-1:1]};
            r_q     <= {w_sum[0], r_q[W1-1:1]};
            r_qprev <= r_q[0];
        end
    end

    // Low 2*WIDTH bits of the 2*W1-bit {A,Q} result.
    assign o_product = {r_a[WIDTH-2:0], r_q};

endmodule

// File: rtl/booth_mult_seq.sv
// rtl/booth_mult_seq.sv - sequential radix-2 Booth multiplier with valid/ready handshakes and flush
module booth_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);
    import mult_pkg::*;

    localparam int W1 = calc_w1(WIDTH);
    localparam int CW = $clog2(W1 + 1);

    if ((WIDTH < 2) || (WIDTH > 32)) begin : g_bad_width
        $error("booth_mult_seq: WIDTH must be in 2..32");
    end

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic            w_load;
    logic            w_clear;
    logic            w_step;
    logic [2*WIDTH-1:0] w_product;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and datapath strobes; flush overrides both handshakes.
    always_comb begin
        w_next  = r_state;
        w_load  = 1'b0;
        w_clear = 1'b0;
        w_step  = 1'b0;
        if (flush) begin
            w_next  = IDLE;
            w_clear = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        w_load = 1'b1;
                        w_next = BUSY;
                    end
                end
                BUSY: begin
                    w_step = 1'b1;
                    if (r_cnt == CW'(W1 - 1)) begin
                        w_next = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        w_next = IDLE;
                    end
                end
                default: begin
                    w_next  = IDLE;
                    w_clear = 1'b1;
                end
            endcase
        end
    end

    // Iteration counter, saturating at W1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_clear || w_load) begin
            r_cnt <= '0;
        end else if (w_step && (r_cnt != CW'(W1))) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    booth_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk            (clk),
        .reset          (reset),
        .i_load         (w_load),
        .i_clear        (w_clear),
        .i_step         (w_step),
        .i_signed_mode  (signed_mode),
        .i_multiplicand (multiplicand),
        .i_multiplier   (multiplier),
        .o_product      (w_product)
    );

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign product   = out_valid ? w_product : '0;

endmodule

// File: tb/tb_booth_mult_seq.sv
// tb/tb_booth_mult_seq.sv - directed and random checks of booth_mult_seq at WIDTH=8 and WIDTH=16
module tb_booth_mult_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;

    logic        flush_8, in_valid_8, signed_8, out_ready_8;
    logic [7:0]  mcand_8, mplier_8;
    logic        in_ready_8, out_valid_8;
    logic [15:0] product_8;

    logic        flush_16, in_valid_16, signed_16, out_ready_16;
    logic [15:0] mcand_16, mplier_16;
    logic        in_ready_16, out_valid_16;
    logic [31:0] product_16;

    int checks = 0;
    int failures = 0;

    booth_mult_seq #(.WIDTH(8)) u_dut8 (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush_8),
        .in_valid     (in_valid_8),
        .in_ready     (in_ready_8),
        .multiplicand (mcand_8),
        .multiplier   (mplier_8),
        .signed_mode  (signed_8),
        .out_valid    (out_valid_8),
        .out_ready    (out_ready_8),
        .product      (product_8)
    );

    booth_mult_seq #(.WIDTH(16)) u_dut16 (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush_16),
        .in_valid     (in_valid_16),
        .in_ready     (in_ready_16),
        .multiplicand (mcand_16),
        .multiplier   (mplier_16),
        .signed_mode  (signed_16),
        .out_valid    (out_valid_16),
        .out_ready    (out_ready_16),
        .product      (product_16)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: interpret operands as integers and multiply, keep 2*w bits.
    function automatic logic [63:0] ref_product(input int w, input logic [31:0] m,
                                                input logic [31:0] q, input bit s);
        longint a, b, p;
        logic [63:0] mask;
        a = longint'({32'd0, m});
        b = longint'({32'd0, q});
        if (s && m[w-1]) a = a - (longint'(1) << w);
        if (s && q[w-1]) b = b - (longint'(1) << w);
        p = a * b;
        mask = (64'd1 << (2 * w)) - 64'd1;
        return 64'(p) & mask;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input int w, input logic v, input logic [31:0] m,
                         input logic [31:0] q, input bit s);
        if (w == 8) begin
            in_valid_8 = v; mcand_8 = m[7:0]; mplier_8 = q[7:0]; signed_8 = s;
        end else begin
            in_valid_16 = v; mcand_16 = m[15:0]; mplier_16 = q[15:0]; signed_16 = s;
        end
    endtask

    task automatic set_oready(input int w, input logic v);
        if (w == 8) out_ready_8 = v;
        else        out_ready_16 = v;
    endtask

    function automatic logic rdy(input int w);
        return (w == 8) ? in_ready_8 : in_ready_16;
    endfunction

    function automatic logic ovalid(input int w);
        return (w == 8) ? out_valid_8 : out_valid_16;
    endfunction

    function automatic logic [63:0] prod(input int w);
        return (w == 8) ? 64'(product_8) : 64'(product_16);
    endfunction

    // One complete transaction: accept, latency, result, output handshake, back in IDLE.
    task automatic run_op(input string tag, input int w, input logic [31:0] m,
                          input logic [31:0] q, input bit s, input logic [63:0] exp_prod);
        int n;
        check({tag, ":ready_before"}, 64'(rdy(w)), 64'd1);
        offer(w, 1'b1, m, q, s);
        cyc();
        offer(w, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ~s);
        check({tag, ":busy_ready"}, 64'(rdy(w)), 64'd0);
        check({tag, ":busy_product"}, prod(w), 64'd0);
        n = 0;
        while (!ovalid(w) && n < 100) begin
            cyc();
            n++;
        end
        check({tag, ":latency"}, 64'(n), 64'(w + 1));
        check({tag, ":product"}, prod(w), exp_prod);
        set_oready(w, 1'b1);
        cyc();
        set_oready(w, 1'b0);
        check({tag, ":idle_valid"}, 64'(ovalid(w)), 64'd0);
        check({tag, ":idle_ready"}, 64'(rdy(w)), 64'd1);
    endtask

    task automatic watch_no_valid(input string tag, input int w, input int cycles);
        int cnt;
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            cyc();
            if (ovalid(w)) cnt++;
        end
        check(tag, 64'(cnt), 64'd0);
    endtask

    initial begin
        logic [31:0] rm, rq;
        bit          rs;
        int          n;

        reset = 1'b1;
        flush_8 = 1'b0;  out_ready_8 = 1'b0;  offer(8, 1'b0, 32'd0, 32'd0, 1'b0);
        flush_16 = 1'b0; out_ready_16 = 1'b0; offer(16, 1'b0, 32'd0, 32'd0, 1'b0);
        #12;
        check("rst_ready8", 64'(in_ready_8), 64'd1);
        check("rst_valid8", 64'(out_valid_8), 64'd0);
        check("rst_product8", 64'(product_8), 64'd0);
        check("rst_ready16", 64'(in_ready_16), 64'd1);
        cyc();
        reset = 1'b0;
        cyc();

        run_op("s_m128_sq", 8, 32'h80, 32'h80, 1'b1, 64'h4000);
        run_op("u_255_sq", 8, 32'hFF, 32'hFF, 1'b0, 64'hFE01);
        run_op("s_m1x127", 8, 32'hFF, 32'h7F, 1'b1, 64'hFF81);
        run_op("u_ffx7f", 8, 32'hFF, 32'h7F, 1'b0, 64'h7E81);

        // Backpressure in DONE with stray in_valid pulses.
        offer(8, 1'b1, 32'd5, 32'd6, 1'b0);
        cyc();
        offer(8, 1'b0, 32'd0, 32'd0, 1'b0);
        n = 0;
        while (!out_valid_8 && n < 100) begin cyc(); n++; end
        check("bp_latency", 64'(n), 64'd9);
        for (int i = 0; i < 5; i++) begin
            offer(8, (i % 2 == 0), 32'hAA, 32'hBB, 1'b1);
            cyc();
            check("bp_product", 64'(product_8), 64'h1E);
            check("bp_ready", 64'(in_ready_8), 64'd0);
            check("bp_valid", 64'(out_valid_8), 64'd1);
        end
        offer(8, 1'b0, 32'd0, 32'd0, 1'b0);
        out_ready_8 = 1'b1;
        cyc();
        out_ready_8 = 1'b0;
        check("bp_after_ready", 64'(in_ready_8), 64'd1);
        watch_no_valid("bp_ignored_pair", 8, 12);

        // Asynchronous reset after four BUSY cycles.
        offer(8, 1'b1, 32'h10, 32'h20, 1'b1);
        cyc();
        offer(8, 1'b0, 32'd0, 32'd0, 1'b0);
        repeat (4) cyc();
        #2 reset = 1'b1;
        #1;
        check("mid_rst_ready", 64'(in_ready_8), 64'd1);
        check("mid_rst_valid", 64'(out_valid_8), 64'd0);
        check("mid_rst_product", 64'(product_8), 64'd0);
        cyc();
        reset = 1'b0;
        watch_no_valid("mid_rst_discard", 8, 12);
        run_op("s_3xm5", 8, 32'h03, 32'hFB, 1'b1, 64'hFFF1);
        watch_no_valid("s_3xm5_single", 8, 15);

        // Flush beats an input handshake at the same edge.
        offer(8, 1'b1, 32'd2, 32'd2, 1'b0);
        flush_8 = 1'b1;
        cyc();
        flush_8 = 1'b0;
        offer(8, 1'b0, 32'd0, 32'd0, 1'b0);
        check("flush_prio_ready", 64'(in_ready_8), 64'd1);
        watch_no_valid("flush_prio_none", 8, 12);

        for (int i = 0; i < 24; i++) begin
            rm = $urandom & 32'hFF;
            rq = $urandom & 32'hFF;
            rs = 1'($urandom_range(0, 1));
            run_op("rand8", 8, rm, rq, rs, ref_product(8, rm, rq, rs));
        end

        run_op("s16_min_x_max", 16, 32'h8000, 32'h7FFF, 1'b1, 64'hC000_8000);

        // Flush while BUSY on the 16-bit instance.
        offer(16, 1'b1, 32'h1234, 32'h5678, 1'b0);
        cyc();
        offer(16, 1'b0, 32'd0, 32'd0, 1'b0);
        repeat (3) cyc();
        flush_16 = 1'b1;
        cyc();
        flush_16 = 1'b0;
        check("flush16_ready", 64'(in_ready_16), 64'd1);
        check("flush16_valid", 64'(out_valid_16), 64'd0);
        check("flush16_product", 64'(product_16), 64'd0);
        watch_no_valid("flush16_none", 16, 25);

        for (int i = 0; i < 8; i++) begin
            rm = $urandom & 32'hFFFF;
            rq = $urandom & 32'hFFFF;
            rs = 1'($urandom_range(0, 1));
            run_op("rand16", 16, rm, rq, rs, ref_product(16, rm, rq, rs));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/booth_mult_seq.md
BOOTH_MULT_SEQ -- requirements
Module: booth_mult_seq

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range is 2..32.
REQ-002 The module SHALL have port clk, input, 1 bit: the clock.
REQ-003 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The module SHALL have port flush, input, 1 bit: synchronous abort.
REQ-005 The module SHALL have port in_valid, input, 1 bit: an operand pair is offered.
REQ-006 The module SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-007 The module SHALL have port multiplicand, input, WIDTH bits: operand M.
REQ-008 The module SHALL have port multiplier, input, WIDTH bits: operand Q.
REQ-009 The module SHALL have port signed_mode, input, 1 bit: 1 selects two's-complement operands, 0 selects unsigned operands; it is sampled with the operands.
REQ-010 The module SHALL have port out_valid, output, 1 bit: product is valid.
REQ-011 The module SHALL have port out_ready, input, 1 bit: the consumer accepts the product.
REQ-012 The module SHALL have port product, output, 2*WIDTH bits: the result.

Function
REQ-013 The block SHALL implement a radix-2 Booth multiplier with internal width W1 = WIDTH+1.
- Operands are sign-extended when signed_mode=1 and zero-extended when signed_mode=0.
- product is the low 2*WIDTH bits of the 2*W1-bit Booth result {A,Q}.
REQ-014 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 An input handshake (in_valid and in_ready at a clock edge) SHALL have the following effect at that edge:
- M is loaded with the extended multiplicand.
- Q is loaded with the extended multiplier.
- A is cleared to 0, Qprev is cleared to 0 and the iteration counter is cleared to 0.
- The state becomes BUSY.
REQ-017 Each BUSY cycle SHALL perform one full Booth iteration at a single edge:
- {Q0,Qprev} = 01: A+M.
- {Q0,Qprev} = 10: A-M.
- {Q0,Qprev} = 00 or 11: A unchanged.
- Then an arithmetic right shift of {A,Q,Qprev} by one, and counter+1.
REQ-018 A+M and A-M SHALL be computed modulo 2^W1 before the shift, and the shift SHALL replicate the MSB of the updated A.
REQ-019 After exactly W1 iterations the state SHALL become DONE, so out_valid rises W1 edges after the accepting edge (9 for WIDTH=8).
REQ-020 The iteration counter SHALL be $clog2(W1+1) bits wide and SHALL stop at W1 without wrapping.
REQ-021 In DONE, product SHALL be held stable until an output handshake (out_valid and out_ready).
REQ-022 An output handshake SHALL return the block to IDLE, and in_ready SHALL be 1 on the following cycle.
REQ-023 in_valid SHALL be ignored in BUSY and DONE, and operand inputs SHALL not affect a running operation.
REQ-024 product SHALL be 0 in IDLE and BUSY.
REQ-025 flush=1 at a clock edge SHALL force IDLE, clear A, Q, Qprev, M and the counter, and discard any in-flight or pending result.
REQ-026 flush SHALL take priority over both handshakes at the same edge.
REQ-027 Back-to-back operation SHALL need no idle cycle other than the mandatory IDLE cycle after DONE.

Reset
REQ-028 reset=1 SHALL asynchronously force IDLE and clear all registers, giving in_ready=1, out_valid=0 and product=0.
REQ-029 Reset mid-operation SHALL discard the operation and produce no out_valid after reset is released.

Structure
REQ-030 Package mult_pkg SHALL hold the following, and no other shared items:
- The state enum type (IDLE, BUSY, DONE).
- The function computing W1 from WIDTH.
REQ-031 The A/Q/Qprev/M registers and the add/sub/shift logic SHALL be in sub-module booth_datapath, controlled by the FSM in booth_mult_seq through load, clear and step strobes.
REQ-032 An illegal WIDTH SHALL cause an elaboration-time assertion failure.

Verification
REQ-033 The bench SHALL cover these directed scenarios (WIDTH=8 unless stated):
- Signed -128 x -128 -> product 0x4000 (16384), 9 edges after accept.
- Unsigned 255 x 255 -> product 0xFE01 (65025).
- Signed -1 x 127 -> product 0xFF81; unsigned 0xFF x 0x7F -> 0x7E81.
- out_ready held low for 5 cycles in DONE, with in_valid pulsed -> product stable, in_ready=0, second operand pair ignored; completes correctly after out_ready=1.
- Reset asserted after 4 BUSY cycles, then a new signed 3 x -5 -> only one out_valid, with product 0xFFF1.
- WIDTH=16: signed -32768 x 32767 -> product 0xC0008000, after 17 edges; flush in BUSY -> IDLE next cycle with no out_valid.
